tanh_pair_drain: RTL and testbench

- Downstream stage of the 2-lane SIMD tanh pipeline.
- Captures each (y0, y1) Q5.11 result pair that the pipeline emits on a valid-only interface, which has no backpressure.
- Buffers the pairs in a small FIFO and serialises them into a single-sample valid/ready stream: lane 0 first, then lane 1.
- Provides a space_ok credit signal so the feeder can gate valid_in, plus drop accounting for when credit is ignored.

---
 rtl/tanh_pkg.sv | 16 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/tanh_pair_drain.sv | 81 ++++++++
 tb/tb_tanh_pair_drain.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tanh_pkg.sv
// Shared Q5.11 constants and the lane-pair bundle
// used by the 2-lane tanh pipeline and its drain stage.
package tanh_pkg;

   localparam int DATA_W = 16;
   localparam int FRAC_W = 11;

   localparam logic [DATA_W-1:0] Q_ONE     = 16'h0800;
   localparam logic [DATA_W-1:0] Q_NEG_ONE = 16'hF800;

   typedef struct packed {
      logic [DATA_W-1:0] y1;
      logic [DATA_W-1:0] y0;
   } pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head read.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   // Storage carries no reset; count alone decides validity.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/tanh_pair_drain.sv
// Serialises (y0, y1) tanh pairs into a single-sample
// valid/ready stream, with credit and drop accounting.
module tanh_pair_drain
   import tanh_pkg::*;
#(
   parameter int DATA_W   = tanh_pkg::DATA_W,
   parameter int DEPTH    = 8,
   parameter int PIPE_LAT = 3,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_y0,
   input  logic [DATA_W-1:0] in_y1,
   output logic              space_ok,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_lane,
   input  logic              out_ready,
   output logic [CW-1:0]     level,
   output logic              overflow,
   output logic [15:0]       drop_cnt
);

   localparam logic [CW-1:0] FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] CREDIT = CW'(DEPTH - (PIPE_LAT + 1));

   typedef enum logic {LANE0 = 1'b0, LANE1 = 1'b1} sel_t;

   sel_t          sel;
   pair_t         in_pair;
   pair_t         head;
   logic [CW-1:0] count;
   logic          transfer;
   logic          pop;
   logic          push;

   assign in_pair  = '{y1: in_y1, y0: in_y0};
   assign transfer = out_valid & out_ready;
   assign pop      = transfer & (sel == LANE1);
   // A full FIFO still takes a pair when its head leaves this cycle.
   assign push     = in_valid & ((count < FULL) | pop);

   sync_fifo #(
      .WIDTH($bits(pair_t)),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .wdata(in_pair),
      .head (head),
      .count(count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sel      <= LANE0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (transfer)
            sel <= (sel == LANE0) ? LANE1 : LANE0;
         if (in_valid && !push) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   assign out_valid = (count != '0);
   assign out_lane  = sel;
   assign out_data  = !out_valid        ? '0 :
                      (sel == LANE1)    ? head.y1 : head.y0;
   assign level     = count;
   assign space_ok  = (count <= CREDIT);

endmodule

// File: tb/tb_tanh_pair_drain.sv
// Scoreboard bench for tanh_pair_drain: a cycle model
// predicts occupancy, lane order and drops.
module tb_tanh_pair_drain;
   import tanh_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [15:0] in_y0 = '0;
   logic [15:0] in_y1 = '0;
   logic        space_ok;
   logic        out_valid;
   logic [15:0] out_data;
   logic        out_lane;
   logic        out_ready = 1'b0;
   logic [3:0]  level;
   logic        overflow;
   logic [15:0] drop_cnt;

   tanh_pair_drain dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_y0    (in_y0),
      .in_y1    (in_y1),
      .space_ok (space_ok),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_lane (out_lane),
      .out_ready(out_ready),
      .level    (level),
      .overflow (overflow),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [16:0] sb[$];
   int          mcount = 0;
   logic        msel = 1'b0;
   logic        mov = 1'b0;
   logic [15:0] mdrop = '0;
   logic [15:0] tv[20];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
      end
   endtask

   // Called just after a falling edge; checks, then advances the model.
   task automatic cycle(input logic iv, input logic [15:0] a,
                        input logic [15:0] b, input logic rdy);
      logic xfer, mpop, mpush;
      in_valid  = iv;
      in_y0     = a;
      in_y1     = b;
      out_ready = rdy;
      #1;
      chk("out_valid", 32'(out_valid), 32'(mcount != 0));
      if (mcount != 0) begin
         chk("out_data", 32'(out_data), 32'(sb[0][15:0]));
         chk("out_lane", 32'(out_lane), 32'(sb[0][16]));
      end else begin
         chk("idle_data", 32'(out_data), 32'(0));
      end
      chk("level", 32'(level), 32'(mcount));
      chk("space_ok", 32'(space_ok), 32'(mcount <= 4));
      chk("overflow", 32'(overflow), 32'(mov));
      chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
      xfer  = (mcount != 0) && rdy;
      mpop  = xfer && msel;
      mpush = iv && ((mcount < 8) || mpop);
      if (xfer) begin
         void'(sb.pop_front());
         msel = ~msel;
      end
      if (mpush) begin
         sb.push_back({1'b0, a});
         sb.push_back({1'b1, b});
      end else if (iv) begin
         mov = 1'b1;
         if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
      mcount = mcount + int'(mpush) - int'(mpop);
      @(negedge clk);
   endtask

   task automatic rst_cycle(input logic iv);
      rst       = 1'b1;
      in_valid  = iv;
      in_y0     = Q_ONE;
      in_y1     = Q_NEG_ONE;
      out_ready = 1'b0;
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      sb.delete();
      mcount = 0;
      msel   = 1'b0;
      mov    = 1'b0;
      mdrop  = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && mcount != 0; i++)
         cycle(1'b0, 16'h0, 16'h0, 1'b1);
      chk("drained", 32'(out_valid), 32'(0));
   endtask

   initial begin
      for (int k = 0; k < 20; k++)
         tv[k] = 16'($rtoi($tanh(-5.0 + 10.0 * k / 19.0) * 2048.0));

      @(negedge clk);
      rst_cycle(1'b0);
      rst_cycle(1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b1);

      // single pair, full-rate downstream
      cycle(1'b1, 16'hF801, 16'h07FF, 1'b1);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 16'h0, 16'h0, 1'b1);

      // backpressure then release
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 16'hF801 + 16'(i), 16'h07FF - 16'(i), 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0);
      cycle(1'b1, 16'h1234, 16'hABCD, 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b0);
      drain();

      // overflow, then full-with-pop acceptance
      for (int i = 0; i < 10; i++)
         cycle(1'b1, 16'(i * 16'h0111), 16'(16'hFFFF - i * 16'h0111), 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b1);
      cycle(1'b1, Q_ONE, Q_NEG_ONE, 1'b1);
      cycle(1'b0, 16'h0, 16'h0, 1'b0);
      drain();

      // reset mid-stream with in_valid asserted
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 16'h0A00 + 16'(i), 16'h0B00 + 16'(i), 1'b0);
      rst_cycle(1'b1);
      cycle(1'b0, 16'h0, 16'h0, 1'b0);
      cycle(1'b0, 16'h0, 16'h0, 1'b1);

      // credit-gated tanh sweep with random downstream stalls
      begin
         int idx = 0;
         for (int n = 0; n < 500 && idx < 10; n++) begin
            logic iv;
            iv = (mcount <= 4);
            cycle(iv, tv[2*idx], tv[2*idx+1], 1'($urandom_range(0, 1)));
            if (iv) idx++;
         end
         chk("sweep_fed", 32'(idx), 32'(10));
      end
      drain();
      chk("sweep_overflow", 32'(overflow), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
